// File: rtl/z_regfile_16_if.sv
// Write/read bus of the 16-entry register file: decoder one-hot write port,
// writeback data, two operand read ports and the status outputs.
interface z_regfile_16_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [15:0]       we_onehot;
    logic [DATA_W-1:0] data_in;
    logic [3:0]        rd_sel_a;
    logic [3:0]        rd_sel_b;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              wr_err;
    logic [CNT_W-1:0]  wr_count;

    modport master (
        output we_onehot, data_in, rd_sel_a, rd_sel_b,
        input  data_a, data_b, wr_err, wr_count
    );

    modport slave (
        input  we_onehot, data_in, rd_sel_a, rd_sel_b,
        output data_a, data_b, wr_err, wr_count
    );
endinterface

// File: rtl/z_regfile_16.sv
// 16-entry register file (r0 reads zero) with one-hot write port, multi-hot rejection
// and saturating write counter. Define Z_REGFILE_BYPASS_EN for write-to-read forwarding.
module z_regfile_16 #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic          clock,
    input  logic          reset,
    z_regfile_16_if.slave bus
);

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SINGLE,
        WR_R0,
        WR_MULTI
    } wr_kind_e;

    wr_kind_e          wr_kind;
    logic [3:0]        wr_idx;

    logic [DATA_W-1:0] regs [1:15];
    logic              wr_err_q;
    logic [CNT_W-1:0]  wr_count_q;

    // Classify the enable vector; a value with more than one set bit survives v & (v-1).
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        wr_kind = WR_IDLE;
        wr_idx  = '0;
        if (bus.we_onehot == 16'h0000) begin
            wr_kind = WR_IDLE;
        end else if ((bus.we_onehot & (bus.we_onehot - 16'd1)) != 16'h0000) begin
            wr_kind = WR_MULTI;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (bus.we_onehot[i]) wr_idx = 4'(i);
            end
            wr_kind = (wr_idx == 4'd0) ? WR_R0 : WR_SINGLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the storage array is reset on purpose: r1..r15 must read zero right after reset.
            for (int i = 1; i < 16; i++) regs[i] <= '0;
            wr_err_q   <= 1'b0;
            wr_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (wr_kind)
                WR_SINGLE: begin
                    for (int i = 1; i < 16; i++) begin
                        if (wr_idx == 4'(i)) regs[i] <= bus.data_in;
                    end
                    if (wr_count_q != '1) wr_count_q <= wr_count_q + CNT_W'(1);
                end
                WR_MULTI: wr_err_q <= 1'b1;
                default:  ;
            endcase
        end
    end

    // Read muxes: index 0 has no storage and falls through to the zero default.
    always_comb begin
        bus.data_a = '0;
        bus.data_b = '0;
        for (int i = 1; i < 16; i++) begin
            if (bus.rd_sel_a == 4'(i)) bus.data_a = regs[i];
            if (bus.rd_sel_b == 4'(i)) bus.data_b = regs[i];
        end
`ifdef Z_REGFILE_BYPASS_EN
        // Forwarding follows the decoded write only; reset does not suppress it.
        if (wr_kind == WR_SINGLE && wr_idx == bus.rd_sel_a) bus.data_a = bus.data_in;
        if (wr_kind == WR_SINGLE && wr_idx == bus.rd_sel_b) bus.data_b = bus.data_in;
`endif
    end

    assign bus.wr_err   = wr_err_q;
    assign bus.wr_count = wr_count_q;

endmodule

// File: doc/z_regfile_16.md
Name: z_regfile_16

Overview:
- 16-entry register file. Its write port takes the one-hot 16-bit write-enable vector produced by the 4-to-16 write-select decoder directly.
- Sits in the processor datapath as the decoder's downstream consumer: decoder output feeds we_onehot; writeback data feeds data_in.
- Two asynchronous read ports serve operand fetch.
- r0 is hardwired to zero. Malformed (multi-hot) enable vectors are detected and rejected.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- CNT_W, 16, width of the accepted-write counter.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- we_onehot  input  16  write-enable vector from the write-select decoder; bit i selects register i
- data_in  input  DATA_W  write data
- rd_sel_a  input  4  read port A register index
- rd_sel_b  input  4  read port B register index
- data_a  output  DATA_W  contents of register rd_sel_a
- data_b  output  DATA_W  contents of register rd_sel_b
- wr_err  output  1  sticky flag: a multi-hot we_onehot was presented
- wr_count  output  CNT_W  saturating count of accepted writes

Behaviour:
- Reset:
  - One clock, synchronous, active-high, sampled on the rising edge.
  - Clears r1..r15 to 0, wr_err to 0 and wr_count to 0.
  - Reset has priority over any write presented in the same cycle; that write is discarded and not counted.
- Storage: 15 physical registers, r1..r15. r0 has no storage and always reads 0.
- Write classification, evaluated each rising edge when reset is low:
  - we_onehot == 0: idle. No write, no count, no error.
  - Exactly one bit i set, i != 0: r_i <= data_in at this edge. wr_count increments by 1.
  - Exactly one bit set and it is bit 0: write discarded, no count, no error. Writes to r0 are legal no-ops.
  - Two or more bits set: no register changes, including any bits that would target r1..r15. wr_err <= 1. No count.
- wr_err is sticky. Only reset clears it.
- wr_count:
  - Unsigned, CNT_W bits.
  - Saturates at all-ones; an accepted write at saturation leaves it unchanged (no wrap).
- Read ports:
  - Combinational (zero latency) from current register state.
  - rd_sel == 0 returns 0.
  - Both ports may select the same register simultaneously, with no conflict.
- Read during write (macro undefined):
  - Read returns the old value in the write cycle.
  - New value is visible after the rising edge.
- All outputs are defined, never X, from the first cycle after reset.

Optional Feature:
- Macro: Z_REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: if we_onehot is exactly one-hot at bit i (i != 0) and rd_sel_x == i, data_x = data_in combinationally in that same cycle.
  - No forwarding for r0 or for multi-hot vectors.
  - Reset does not gate forwarding; it affects state only.
- Undefined: no forwarding. Reads always reflect stored state, as described under Behaviour.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, release → data_a/data_b = 0 for every rd_sel 0..15; wr_err = 0; wr_count = 0.
- Basic write/read:
  - Stimulus: we_onehot=16'h0020, data_in=32'hDEADBEEF for one cycle, then we_onehot=0; rd_sel_a=5, rd_sel_b=5.
  - Response: both ports 32'hDEADBEEF after the edge. Same cycle without bypass: 0. wr_count = 1.
- r0 immunity: we_onehot=16'h0001, data_in=32'hFFFFFFFF; rd_sel_a=0 → data_a = 0; wr_count unchanged; wr_err = 0.
- Multi-hot reject:
  - Stimulus: preload r3=32'h11, r7=32'h22; then we_onehot=16'h0088, data_in=32'h99.
  - Response: r3 still 32'h11, r7 still 32'h22; wr_err = 1 and stays 1 over 10 idle cycles; reset clears it.
- Reset priority: reset=1 and we_onehot=16'h0004 in the same cycle → r2 = 0, wr_count = 0 afterward.
- Saturation and bypass:
  - Saturation (CNT_W=4 build): 20 accepted writes → wr_count = 4'hF.
  - Bypass (Z_REGFILE_BYPASS_EN build): we_onehot=16'h8000, data_in=32'hA5A5A5A5, rd_sel_a=15 → data_a = 32'hA5A5A5A5 in the same cycle.
